// File: rtl/rom_ctrl_sched_pkg.sv
// Shared types and constants for the ROM request-port scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rom_ctrl_sched_pkg;

    localparam int unsigned StateW = 6;

    // Sparse state codes, every pair at Hamming distance >= 3, so a single
    // upset cannot turn one legal state into another.
    typedef enum logic [StateW-1:0] {
        StChecker = 6'b001011,
        StDrain   = 6'b110001,
        StBus     = 6'b011110,
        StError   = 6'b100110
    } rom_sched_state_e;

    typedef enum logic {
        OwnerChk = 1'b0,
        OwnerBus = 1'b1
    } owner_e;

    // Width of the post-reset mask counter. It must hold RdLat, so RdLat <= 15.
    localparam int unsigned MaskCntW = 4;

endpackage

// File: rtl/rom_ctrl_inflight_pipe.sv
// In-flight read tracker: RdLat-deep shift register of {vld, owner}.
// Latency: an entry written in cycle t appears on the tail in cycle t+RdLat.
// Backpressure: none; shifts every cycle.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_wr_vld           a read is issued this cycle
//   i_wr_owner         requester that issued it
//   o_tail_vld         a response is due this cycle
//   o_tail_owner       requester the due response belongs to
//   o_empty_nxt        nothing will be in flight after this cycle's shift
module rom_ctrl_inflight_pipe
    import rom_ctrl_sched_pkg::*;
#(
    parameter int unsigned RdLat = 1
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_wr_vld,
    input  owner_e i_wr_owner,
    output logic   o_tail_vld,
    output owner_e o_tail_owner,
    output logic   o_empty_nxt
);

    logic   [RdLat-1:0] r_vld;
    owner_e             r_own [RdLat];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int i = 0; i < RdLat; i++) begin
                r_own[i] <= OwnerChk;
            end
        end else begin
            r_vld[0] <= i_wr_vld;
            r_own[0] <= i_wr_owner;
            for (int i = 1; i < RdLat; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_own[i] <= r_own[i-1];
            end
        end
    end

    // The tail leaves at the next shift, so only the write and the upstream
    // stages decide whether anything remains afterwards.
    always_comb begin
        o_empty_nxt = !i_wr_vld;
        for (int i = 0; i < RdLat - 1; i++) begin
            if (r_vld[i]) begin
                o_empty_nxt = 1'b0;
            end
        end
    end

    assign o_tail_vld   = r_vld[RdLat-1];
    assign o_tail_owner = r_own[RdLat-1];

endmodule

// File: rtl/rom_ctrl_rom_sched.sv
// Shares the scrambled-ROM request port: checker first, then a one-way handover to the bus.
// Latency: grant in cycle t -> owner rvalid in cycle t+RdLat (combinational from rom_*_i).
// Backpressure: none; requesters must take a response in the cycle rvalid is high.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   chk_* / bus_*                  requester ports (req/addr in, gnt/rvalid/rdata out)
//   chk_done_i                     checker finished, starts the handover
//   rom_req_o, rom_addr_o          ROM request and physical-index address
//   prince_addr_o                  keystream-tweak address from an independent mux
//   rom_rvalid_i, rom_*_rdata_i    ROM response
//   bus_sel_o                      bus owns the ROM
//   alert_o                        sticky fatal alert
module rom_ctrl_rom_sched
    import rom_ctrl_sched_pkg::*;
#(
    parameter int unsigned Aw    = 12,
    parameter int unsigned Width = 40,
    parameter int unsigned RdLat = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             chk_req_i,
    input  logic [Aw-1:0]    chk_addr_i,
    output logic             chk_gnt_o,
    output logic             chk_rvalid_o,
    output logic [Width-1:0] chk_scr_rdata_o,
    output logic [Width-1:0] chk_clr_rdata_o,
    input  logic             chk_done_i,
    input  logic             bus_req_i,
    input  logic [Aw-1:0]    bus_addr_i,
    output logic             bus_gnt_o,
    output logic             bus_rvalid_o,
    output logic [Width-1:0] bus_clr_rdata_o,
    output logic             rom_req_o,
    output logic [Aw-1:0]    rom_addr_o,
    output logic [Aw-1:0]    prince_addr_o,
    input  logic             rom_rvalid_i,
    input  logic [Width-1:0] rom_scr_rdata_i,
    input  logic [Width-1:0] rom_clr_rdata_i,
    output logic             bus_sel_o,
    output logic             alert_o
);

    logic [StateW-1:0]   r_state;
    logic [StateW-1:0]   w_state_nxt;
    logic                r_sel_a;
    logic                r_sel_b;
    logic                r_alert;
    logic [MaskCntW-1:0] r_mask_cnt;

    logic   w_chk_gnt;
    logic   w_bus_gnt;
    logic   w_sel_ok;
    logic   w_state_bad;
    logic   w_late_chk;
    logic   w_rsp_bad;
    logic   w_err;
    logic   w_mask;
    logic   w_in_err;
    logic   w_tail_vld;
    owner_e w_tail_owner;
    logic   w_empty_nxt;

    assign w_state_bad = !(r_state inside {StChecker, StDrain, StBus, StError});
    assign w_in_err    = (r_state == StError);
    assign w_sel_ok    = (r_sel_a == r_sel_b);
    assign w_mask      = (r_mask_cnt != '0);
    assign w_late_chk  = chk_req_i && ((r_state == StDrain) || (r_state == StBus));
    // Unexpected responses are tolerated only inside the post-reset window;
    // a missing response is always a fault.
    assign w_rsp_bad   = (rom_rvalid_i && !w_tail_vld && !w_mask)
                       || (!rom_rvalid_i && w_tail_vld);
    assign w_err       = w_state_bad || !w_sel_ok || w_late_chk || w_rsp_bad;

    always_comb begin
        w_state_nxt = r_state;
        w_chk_gnt   = 1'b0;
        w_bus_gnt   = 1'b0;
        case (r_state)
            StChecker: begin
                w_chk_gnt = chk_req_i;
                if (chk_done_i) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (w_empty_nxt) begin
                    w_state_nxt = StBus;
                end
            end
            StBus:   w_bus_gnt = bus_req_i;
            StError: w_state_nxt = StError;
            default: w_state_nxt = StError;
        endcase
        if (w_err) begin
            w_state_nxt = StError;
        end
    end

    // A select-copy mismatch blocks grants, so diverging address copies never
    // reach the ROM as a real read.
    assign chk_gnt_o = w_chk_gnt && w_sel_ok;
    assign bus_gnt_o = w_bus_gnt && w_sel_ok;
    assign rom_req_o = chk_gnt_o || bus_gnt_o;

    assign rom_addr_o    = r_sel_a ? bus_addr_i : chk_addr_i;
    assign prince_addr_o = r_sel_b ? bus_addr_i : chk_addr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StChecker;
            r_sel_a    <= 1'b0;
            r_sel_b    <= 1'b0;
            r_alert    <= 1'b0;
            r_mask_cnt <= MaskCntW'(RdLat);
        end else begin
            r_state <= w_state_nxt;
            r_sel_a <= (w_state_nxt == StBus);
            r_sel_b <= (w_state_nxt == StBus);
            r_alert <= r_alert || w_err;
            if (w_mask) begin
                r_mask_cnt <= r_mask_cnt - MaskCntW'(1);
            end
        end
    end

    rom_ctrl_inflight_pipe #(
        .RdLat (RdLat)
    ) u_pipe (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_wr_vld     (rom_req_o),
        .i_wr_owner   (w_bus_gnt ? OwnerBus : OwnerChk),
        .o_tail_vld   (w_tail_vld),
        .o_tail_owner (w_tail_owner),
        .o_empty_nxt  (w_empty_nxt)
    );

    assign chk_rvalid_o = !w_in_err && w_tail_vld && (w_tail_owner == OwnerChk) && rom_rvalid_i;
    assign bus_rvalid_o = !w_in_err && w_tail_vld && (w_tail_owner == OwnerBus) && rom_rvalid_i;

    assign chk_scr_rdata_o = chk_rvalid_o ? rom_scr_rdata_i : '0;
    assign chk_clr_rdata_o = chk_rvalid_o ? rom_clr_rdata_i : '0;
    assign bus_clr_rdata_o = bus_rvalid_o ? rom_clr_rdata_i : '0;

    assign bus_sel_o = (r_state == StBus);
    assign alert_o   = r_alert;

endmodule
